// File: rtl/imu_sync_pkg.sv
// Shared types and default widths for the IMU synchroniser / camera trigger path.
package imu_sync_pkg;

  localparam int CNT_W = 20;
  localparam int TS_W  = 64;
  localparam int FC_W  = 32;
  localparam int OV_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_t;

endpackage

// File: rtl/trigger_pulse_timer.sv
// Loadable down-counter; done flags the last cycle of the loaded interval.
module trigger_pulse_timer #(
  parameter int CNT_W = imu_sync_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A count of N loaded at the end of cycle k makes done true in cycle k+N.
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/camera_trigger_generator.sv
// Converts trigger_frame rising edges into delayed, width-controlled camera
// triggers, latching timestamp and IMU sample index per frame.
//
// state | meaning
// IDLE  | waiting for an enabled rising edge of trigger_frame
// DELAY | counting the captured delay before the trigger rises
// PULSE | cam_trigger high for the captured width
module camera_trigger_generator #(
  parameter int CNT_W = imu_sync_pkg::CNT_W,
  parameter int TS_W  = imu_sync_pkg::TS_W,
  parameter int FC_W  = imu_sync_pkg::FC_W,
  parameter int OV_W  = imu_sync_pkg::OV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger_frame,
  input  logic [7:0]       sample_count,
  input  logic             enable,
  input  logic [CNT_W-1:0] delay_cycles,
  input  logic [CNT_W-1:0] pulse_cycles,
  output logic             cam_trigger,
  output logic [TS_W-1:0]  frame_ts,
  output logic [7:0]       frame_sample_idx,
  output logic             ts_valid,
  output logic [FC_W-1:0]  frame_count,
  output logic [OV_W-1:0]  overrun_count
);

  import imu_sync_pkg::*;

  state_t           state, state_nx;
  logic             trig_d;
  logic             rise;
  logic [TS_W-1:0]  ts_cnt;
  logic [CNT_W-1:0] pulse_cap;
  logic [CNT_W-1:0] pulse_eff;
  logic [CNT_W-1:0] pls_val;
  logic             dly_load, pls_load;
  logic             dly_done, pls_done;
  logic             start, finish;

  assign rise      = trigger_frame & ~trig_d;
  assign pulse_eff = (pulse_cycles == '0) ? CNT_W'(1) : pulse_cycles;

  trigger_pulse_timer #(.CNT_W(CNT_W)) u_delay_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (delay_cycles),
    .done     (dly_done)
  );

  trigger_pulse_timer #(.CNT_W(CNT_W)) u_pulse_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (pls_load),
    .load_val (pls_val),
    .done     (pls_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    dly_load = 1'b0;
    pls_load = 1'b0;
    pls_val  = pulse_cap;
    start    = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (rise && enable) begin
          start = 1'b1;
          if (delay_cycles == '0) begin
            // Zero delay bypasses the capture register, so load the live value.
            state_nx = PULSE;
            pls_load = 1'b1;
            pls_val  = pulse_eff;
          end else begin
            state_nx = DELAY;
            dly_load = 1'b1;
          end
        end
      end
      DELAY: begin
        if (dly_done) begin
          state_nx = PULSE;
          pls_load = 1'b1;
        end
      end
      PULSE: begin
        if (pls_done) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_d           <= 1'b1;
      ts_cnt           <= '0;
      cam_trigger      <= 1'b0;
      ts_valid         <= 1'b0;
      frame_ts         <= '0;
      frame_sample_idx <= '0;
      frame_count      <= '0;
      overrun_count    <= '0;
      pulse_cap        <= '0;
    end else begin
      trig_d      <= trigger_frame;
      ts_cnt      <= ts_cnt + 1'b1;
      cam_trigger <= (state_nx == PULSE);
      ts_valid    <= finish;
      if (finish) frame_count <= frame_count + 1'b1;
      if (start) begin
        frame_ts         <= ts_cnt;
        frame_sample_idx <= sample_count;
        pulse_cap        <= pulse_eff;
      end
      if (rise && enable && (state != IDLE) && (overrun_count != '1))
        overrun_count <= overrun_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_camera_trigger_generator.sv
// Scoreboard bench: expected frames are queued at stimulus time and checked
// by a monitor on each ts_valid strobe.
module tb_camera_trigger_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger_frame = 1'b1;
  logic [7:0]  sample_count = 8'd0;
  logic        enable = 1'b1;
  logic [19:0] delay_cycles = 20'd0;
  logic [19:0] pulse_cycles = 20'd0;
  logic        cam_trigger;
  logic [63:0] frame_ts;
  logic [7:0]  frame_sample_idx;
  logic        ts_valid;
  logic [31:0] frame_count;
  logic [15:0] overrun_count;

  camera_trigger_generator dut (
    .clk              (clk),
    .rst              (rst),
    .trigger_frame    (trigger_frame),
    .sample_count     (sample_count),
    .enable           (enable),
    .delay_cycles     (delay_cycles),
    .pulse_cycles     (pulse_cycles),
    .cam_trigger      (cam_trigger),
    .frame_ts         (frame_ts),
    .frame_sample_idx (frame_sample_idx),
    .ts_valid         (ts_valid),
    .frame_count      (frame_count),
    .overrun_count    (overrun_count)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset; matches the timestamp counter by construction.
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef struct {
    int          start;
    int          width;
    int          vcyc;
    logic [63:0] ts;
    logic [7:0]  idx;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   valid_seen = 0;
  int   cam_high_cnt = 0;
  int   pstart = -1;
  logic prev_cam = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int s, input int w, input int v, input int ts, input int idx, input int fc);
    exp_t e;
    e.start = s; e.width = w; e.vcyc = v;
    e.ts = 64'(ts); e.idx = 8'(idx); e.fc = 32'(fc);
    sb.push_back(e);
  endtask

  // Stops at the negedge of cycle n; inputs are then driven #1 later by the caller.
  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != n && guard < 1000);
    if (cyc != n) chk("wait_timeout", 64'(cyc), 64'(n));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_cam = 1'b0;
    end else begin
      if (cam_trigger) cam_high_cnt++;
      if (cam_trigger && !prev_cam) pstart = cyc;
      if (ts_valid) begin
        valid_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_ts_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_start", 64'(pstart), 64'(e.start));
          chk("pulse_width", 64'(cyc - pstart), 64'(e.width));
          chk("ts_valid_cycle", 64'(cyc), 64'(e.vcyc));
          chk("cam_low_at_valid", 64'(cam_trigger), 64'd0);
          chk("frame_ts", frame_ts, e.ts);
          chk("frame_sample_idx", 64'(frame_sample_idx), 64'(e.idx));
          chk("frame_count", 64'(frame_count), 64'(e.fc));
        end
      end
      prev_cam = cam_trigger;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset release with trigger_frame already high: no frame may appear.
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_cyc(100);
    chk("idle_cam_trigger", 64'(cam_trigger), 64'd0);
    chk("idle_cam_high_cnt", 64'(cam_high_cnt), 64'd0);
    chk("idle_frame_count", 64'(frame_count), 64'd0);
    chk("idle_overrun", 64'(overrun_count), 64'd0);
    chk("idle_valid_seen", 64'(valid_seen), 64'd0);
    chk("idle_frame_ts", frame_ts, 64'd0);

    // Fresh reference: timestamp and bench cycle both restart at 0.
    #1 rst = 1'b1; trigger_frame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    enable = 1'b1; delay_cycles = 20'd5; pulse_cycles = 20'd3; sample_count = 8'd7;
    wait_cyc(20);
    #1 trigger_frame = 1'b1;
    push(26, 3, 29, 20, 7, 1);
    wait_cyc(40);
    #1 trigger_frame = 1'b0;

    // Zero delay, zero width -> one-cycle pulse right after the edge.
    wait_cyc(45);
    #1 delay_cycles = 20'd0; pulse_cycles = 20'd0; sample_count = 8'd9;
    wait_cyc(50);
    #1 trigger_frame = 1'b1;
    push(51, 1, 52, 50, 9, 2);
    wait_cyc(60);
    #1 trigger_frame = 1'b0;

    // Second edge during the delay is dropped and counted as overrun.
    wait_cyc(65);
    #1 delay_cycles = 20'd10; pulse_cycles = 20'd10; sample_count = 8'd3;
    wait_cyc(70);
    #1 trigger_frame = 1'b1;
    push(81, 10, 91, 70, 3, 3);
    wait_cyc(72);
    #1 trigger_frame = 1'b0; sample_count = 8'd4;
    wait_cyc(74);
    #1 trigger_frame = 1'b1;
    wait_cyc(95);
    chk("overrun_after_drop", 64'(overrun_count), 64'd1);
    chk("idx_kept_first", 64'(frame_sample_idx), 64'd3);
    #1 trigger_frame = 1'b0;

    // Edge with enable low is ignored entirely.
    wait_cyc(100);
    #1 enable = 1'b0;
    wait_cyc(110);
    #1 trigger_frame = 1'b1;
    wait_cyc(115);
    #1 trigger_frame = 1'b0;
    wait_cyc(130);
    chk("disabled_overrun", 64'(overrun_count), 64'd1);
    chk("disabled_frame_count", 64'(frame_count), 64'd3);
    chk("disabled_valid_seen", 64'(valid_seen), 64'd3);
    #1 enable = 1'b1; delay_cycles = 20'd6; pulse_cycles = 20'd2; sample_count = 8'd5;

    // Enable dropped and config changed mid-delay: captured values still apply.
    wait_cyc(140);
    #1 trigger_frame = 1'b1;
    push(147, 2, 149, 140, 5, 4);
    wait_cyc(143);
    #1 enable = 1'b0; delay_cycles = 20'd1; pulse_cycles = 20'd20;
    wait_cyc(150);
    #1 trigger_frame = 1'b0; enable = 1'b1;

    // Reset in the second cycle of an 8-cycle pulse.
    wait_cyc(160);
    #1 delay_cycles = 20'd2; pulse_cycles = 20'd8; sample_count = 8'd11;
    wait_cyc(170);
    #1 trigger_frame = 1'b1;
    wait_cyc(174);
    chk("pulse_in_flight", 64'(cam_trigger), 64'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_cam_trigger", 64'(cam_trigger), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_overrun", 64'(overrun_count), 64'd0);
    chk("rst_frame_ts", frame_ts, 64'd0);
    chk("rst_ts_valid", 64'(ts_valid), 64'd0);
    #1 rst = 1'b0;

    wait_cyc(5);
    #1 trigger_frame = 1'b0; delay_cycles = 20'd1; pulse_cycles = 20'd1; sample_count = 8'd2;
    wait_cyc(10);
    #1 trigger_frame = 1'b1;
    push(12, 1, 13, 10, 2, 1);
    wait_cyc(20);
    #1 trigger_frame = 1'b0;
    wait_cyc(30);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("total_valid_seen", 64'(valid_seen), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
